// File: rtl/data_memory_block_if.sv
// data_memory_block_if: cache-to-memory block bus with level-held read/write requests and busywait.
interface data_memory_block_if #(
  parameter int AW = 6
);
  logic mem_read;
  logic mem_write;
  logic [AW-1:0] mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic mem_busywait;
  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );
  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/data_memory_block.sv
// data_memory_block: fixed-latency 32-bit block memory behind the data cache.
// Optional MEM_ACCESS_STATS_EN adds saturating read/write completion counters.
module data_memory_block #(
  parameter int BLOCKS = 64,
  parameter int LATENCY = 5
) (
  input logic clock,
  input logic reset,
  data_memory_block_if.slave bus
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_writes
`endif
);
  localparam int AW = $clog2(BLOCKS);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  logic is_write;
  logic [31:0] mem [BLOCKS];
  logic req;
  assign req = bus.mem_read | bus.mem_write;
  assign bus.mem_busywait = (state == IDLE && req) || state == BUSY;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      addr <= '0;
      wdata <= '0;
      is_write <= 1'b0;
      bus.mem_readdata <= '0;
      for (int i = 0; i < BLOCKS; i++) mem[i] <= '0;
`ifdef MEM_ACCESS_STATS_EN
      stat_reads <= '0;
      stat_writes <= '0;
`endif
    end else
      case (state)
        IDLE:
          if (req) begin
            addr <= AW'(int'(bus.mem_address) % BLOCKS);
            wdata <= bus.mem_writedata;
            is_write <= bus.mem_write;
            count <= CW'(1);
            state <= BUSY;
          end
        BUSY:
          if (count == CW'(LATENCY)) begin
            if (is_write) mem[addr] <= wdata;
            else bus.mem_readdata <= mem[addr];
`ifdef MEM_ACCESS_STATS_EN
            if (is_write) stat_writes <= stat_writes + {15'd0, stat_writes != 16'hFFFF};
            else stat_reads <= stat_reads + {15'd0, stat_reads != 16'hFFFF};
`endif
            count <= '0;
            state <= ACK;
          end else count <= count + CW'(1);
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_data_memory_block.sv
// tb_data_memory_block: directed checks of latency, handshake, reset and write-priority behaviour.
module tb_data_memory_block;
  localparam int LAT = 5;
  logic clk;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  int n;
  data_memory_block_if bus ();
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] stat_reads, stat_writes;
`endif
  data_memory_block #(.BLOCKS(64), .LATENCY(LAT)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .stat_reads(stat_reads),
    .stat_writes(stat_writes)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wait_done();
    n = 0;
    while (bus.mem_busywait && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic op(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] d, input string tag);
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.mem_address = a;
    bus.mem_writedata = d;
    #1;
    chk({tag, "_busy_rise"}, 32'(bus.mem_busywait), 1);
    wait_done();
    chk({tag, "_edges"}, n, LAT + 1);
  endtask
  task automatic idle();
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(bus.mem_busywait), 0);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_address = '0;
    bus.mem_writedata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_busy", 32'(bus.mem_busywait), 0);
    chk("reset_rdata", bus.mem_readdata, 0);
    op(1'b1, 1'b0, 6'h15, 32'h0, "rd15");
    chk("rd15_data", bus.mem_readdata, 32'h0);
    idle();
    op(1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, "wr2a");
    idle();
    op(1'b1, 1'b0, 6'h2A, 32'h0, "rd2a");
    chk("rd2a_data", bus.mem_readdata, 32'hDEADBEEF);
    idle();
    chk("rd2a_hold", bus.mem_readdata, 32'hDEADBEEF);
    op(1'b0, 1'b1, 6'h09, 32'h11223344, "wb09");
    chk("wb_ack_ignored", 32'(bus.mem_busywait), 0);
    @(posedge clk);
    #1;
    op(1'b1, 1'b0, 6'h29, 32'h0, "fetch29");
    chk("fetch29_data", bus.mem_readdata, 32'h0);
    idle();
    op(1'b1, 1'b0, 6'h09, 32'h0, "rd09");
    chk("rd09_data", bus.mem_readdata, 32'h11223344);
    idle();
`ifdef MEM_ACCESS_STATS_EN
    chk("stat_writes_wb", 32'(stat_writes), 2);
    chk("stat_reads_wb", 32'(stat_reads), 4);
`endif
    op(1'b0, 1'b1, 6'h01, 32'h0BADF00D, "wr01");
    idle();
    op(1'b0, 1'b1, 6'h02, 32'h12345678, "wr02");
    idle();
    bus.mem_read = 1'b1;
    bus.mem_address = 6'h01;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.mem_address = 6'h02;
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    chk("drop_busy_held", 32'(bus.mem_busywait), 1);
    wait_done();
    chk("midchg_edges", n, LAT - 2);
    chk("midchg_data", bus.mem_readdata, 32'h0BADF00D);
    @(posedge clk);
    #1;
    bus.mem_write = 1'b1;
    bus.mem_address = 6'h3F;
    bus.mem_writedata = 32'hCAFEF00D;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    bus.mem_write = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(bus.mem_busywait), 0);
    chk("rst_mid_rdata", bus.mem_readdata, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    op(1'b1, 1'b1, 6'h05, 32'hA5A5A5A5, "both05");
    chk("both05_noread", bus.mem_readdata, 32'h0);
    idle();
`ifdef MEM_ACCESS_STATS_EN
    chk("stat_writes_both", 32'(stat_writes), 1);
    chk("stat_reads_both", 32'(stat_reads), 0);
`endif
    op(1'b1, 1'b0, 6'h05, 32'h0, "rd05");
    chk("rd05_data", bus.mem_readdata, 32'hA5A5A5A5);
    idle();
    op(1'b1, 1'b0, 6'h3F, 32'h0, "rd3f");
    chk("rd3f_data", bus.mem_readdata, 32'h0);
    idle();
    op(1'b1, 1'b0, 6'h2A, 32'h0, "rd2a_cleared");
    chk("rd2a_cleared_data", bus.mem_readdata, 32'h0);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
